// File: rtl/mips_encoder.sv
// mips_encoder: packs symbolic instruction requests into 32-bit MIPS words and
// writes them to instruction memory at consecutive word addresses.
// Ports:
//   clock, reset (async, active-low)
//   in_valid / in_ready          request handshake (accepted only in IDLE)
//   mnem, rs, rt, rd, imm        symbolic request fields
//   imem_we, imem_addr, imem_data  instruction-memory write port
//   count                        words written since reset
//   err                          sticky: an illegal mnemonic was accepted
//   full                         count has reached DEPTH; no further requests
module mips_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h00400000,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [25:0] imm,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  output logic [15:0] count,
  output logic        err,
  output logic        full
);

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned IMM_W   = 26;

  typedef enum logic [1:0] {IDLE, ENC, WR, FULL} state_t;

  state_t             state;
  logic [REG_W-1:0]   mnem_q, rs_q, rt_q, rd_q;
  logic [IMM_W-1:0]   imm_q;
  logic [WORD_W-1:0]  enc_c;
  logic               legal_c;
  logic [CNT_W-1:0]   count_inc_c;

  function automatic logic [31:0] r_word(input logic [4:0] s, input logic [4:0] t,
                                         input logic [4:0] d, input logic [5:0] fn);
    return {6'h00, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] s,
                                         input logic [4:0] t, input logic [15:0] i);
    return {op, s, t, i};
  endfunction

  // Encoder for the latched request; legal_c low for codes 23..31.
  always_comb begin
    enc_c   = '0;
    legal_c = 1'b1;
    case (mnem_q)
      5'd0:  enc_c = r_word(rs_q, rt_q, rd_q, 6'h20);
      5'd1:  enc_c = r_word(rs_q, rt_q, rd_q, 6'h21);
      5'd2:  enc_c = r_word(rs_q, rt_q, rd_q, 6'h22);
      5'd3:  enc_c = r_word(rs_q, rt_q, rd_q, 6'h24);
      5'd4:  enc_c = r_word(rs_q, rt_q, rd_q, 6'h25);
      5'd5:  enc_c = r_word(rs_q, rt_q, rd_q, 6'h27);
      5'd6:  enc_c = r_word(rs_q, rt_q, rd_q, 6'h26);
      5'd7:  enc_c = i_word(6'h08, rs_q, rt_q, imm_q[15:0]);
      5'd8:  enc_c = i_word(6'h09, rs_q, rt_q, imm_q[15:0]);
      5'd9:  enc_c = i_word(6'h0c, rs_q, rt_q, imm_q[15:0]);
      5'd10: enc_c = i_word(6'h0d, rs_q, rt_q, imm_q[15:0]);
      5'd11: enc_c = i_word(6'h0e, rs_q, rt_q, imm_q[15:0]);
      5'd12: enc_c = i_word(6'h04, rs_q, rt_q, imm_q[15:0]);
      5'd13: enc_c = i_word(6'h05, rs_q, rt_q, imm_q[15:0]);
      5'd14: enc_c = {6'h02, imm_q};
      5'd15: enc_c = {6'h00, rs_q, 15'd0, 6'h08};
      5'd16: enc_c = i_word(6'h0f, 5'd0, rt_q, imm_q[15:0]);  // LUI has no rs
      5'd17: enc_c = r_word(rs_q, rt_q, rd_q, 6'h2a);
      5'd18: enc_c = i_word(6'h23, rs_q, rt_q, imm_q[15:0]);
      5'd19: enc_c = i_word(6'h24, rs_q, rt_q, imm_q[15:0]);
      5'd20: enc_c = i_word(6'h2b, rs_q, rt_q, imm_q[15:0]);
      5'd21: enc_c = i_word(6'h28, rs_q, rt_q, imm_q[15:0]);
      5'd22: enc_c = r_word(rs_q, rt_q, rd_q, 6'h2c);
      default: legal_c = 1'b0;
    endcase
  end

  assign count_inc_c = count + CNT_W'(1);

  // Control FSM; in_ready and full are registered alongside the state so they
  // always reflect it exactly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      imem_we   <= 1'b0;
      imem_addr <= BASE_ADDR;
      imem_data <= '0;
      count     <= '0;
      err       <= 1'b0;
      full      <= 1'b0;
      mnem_q    <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mnem_q   <= mnem;
            rs_q     <= rs;
            rt_q     <= rt;
            rd_q     <= rd;
            imm_q    <= imm;
            in_ready <= 1'b0;
            state    <= ENC;
          end
        end
        ENC: begin
          if (legal_c) begin
            imem_data <= enc_c;
            imem_we   <= 1'b1;
            state     <= WR;
          end else begin
            err      <= 1'b1;
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        WR: begin
          imem_we   <= 1'b0;
          imem_addr <= imem_addr + WORD_W'(4);
          count     <= count_inc_c;
          if (count_inc_c == CNT_W'(DEPTH)) begin
            full  <= 1'b1;
            state <= FULL;
          end else begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        FULL: state <= FULL;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
